// File: rtl/aes_parameters.sv
// Shared AES definitions: key-schedule geometry, round key bundle type,
// FSM state encoding, round constants and the forward S-box.
package aes_parameters;

  localparam int ROUND_NUMBER = 14;
  localparam int KEY_WIDTH    = 256;
  localparam int NK           = KEY_WIDTH / 32;
  localparam int NB           = 4;
  localparam int NUM_WORDS    = NB * (ROUND_NUMBER + 1);

  // round_keys[r] = {w[4r], w[4r+1], w[4r+2], w[4r+3]}
  typedef logic [0:ROUND_NUMBER][127:0] round_keys_t;

  typedef enum logic [1:0] {
    KX_IDLE   = 2'd0,
    KX_EXPAND = 2'd1,
    KX_DONE   = 2'd2
  } kx_state_e;

  // Entry 0 is unused so the table can be indexed directly by i/NK.
  localparam logic [7:0] RCON [8] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four byte S-boxes applied to a 32-bit word.
module aes_sub_word
  import aes_parameters::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign o_word[8*b +: 8] = sbox(i_word[8*b +: 8]);
  end

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-256 key schedule: accepts a key, produces one expanded word
// per clock and holds all 15 round keys stable until the next accepted key.
module aes_key_expansion
  import aes_parameters::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] key_in_tdata,
  input  logic                 key_in_tvalid,
  output logic                 key_in_tready,
  input  logic                 keys_hold,
  output round_keys_t          round_keys,
  output logic                 round_keys_valid,
  output logic                 busy,
  output kx_state_e            o_dbg_state
);

  localparam int             CW        = 6;
  localparam logic [CW-1:0]  LAST_WORD = CW'(NUM_WORDS - 1);

  // key_in handshake: a key transfers on a rising clk edge where
  // key_in_tvalid && key_in_tready; tready never depends on tvalid, and
  // tdata is ignored on every other edge.

  kx_state_e     r_state;
  kx_state_e     w_next_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_w [NUM_WORDS];

  logic          w_accept;
  logic [31:0]   w_prev;
  logic [31:0]   w_back;
  logic [31:0]   w_sub_in;
  logic [31:0]   w_sub_out;
  logic [31:0]   w_temp;
  logic [31:0]   w_new;

  assign w_accept    = key_in_tvalid & key_in_tready;
  assign o_dbg_state = r_state;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= KX_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      KX_IDLE:   if (w_accept) w_next_state = KX_EXPAND;
      KX_EXPAND: if (r_cnt == LAST_WORD) w_next_state = KX_DONE;
      KX_DONE:   if (w_accept) w_next_state = KX_EXPAND;
      default:   w_next_state = KX_IDLE;
    endcase
  end

  // Output logic; tready is forced low while reset is asserted.
  always_comb begin
    key_in_tready    = 1'b0;
    busy             = 1'b0;
    round_keys_valid = 1'b0;
    unique case (r_state)
      KX_IDLE:   key_in_tready = !reset;
      KX_EXPAND: busy = 1'b1;
      KX_DONE: begin
        round_keys_valid = 1'b1;
        key_in_tready    = !reset && !keys_hold;
      end
      default: ;
    endcase
  end

  // Word recurrence: w[i] = w[i-8] ^ f(w[i-1]), one shared SubWord.
  assign w_prev   = r_w[r_cnt - CW'(1)];
  assign w_back   = r_w[r_cnt - CW'(NK)];
  assign w_sub_in = (r_cnt[2:0] == 3'd0) ? rot_word(w_prev) : w_prev;

  aes_sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_temp = w_prev;
    if (r_cnt[2:0] == 3'd0) begin
      w_temp = w_sub_out ^ {RCON[r_cnt[5:3]], 24'h000000};
    end else if (r_cnt[2:0] == 3'd4) begin
      w_temp = w_sub_out;
    end
  end

  assign w_new = w_back ^ w_temp;

  // Word register file and write counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        r_w[i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < NK; i++) begin
        r_w[i] <= key_in_tdata[KEY_WIDTH-1-32*i -: 32];
      end
      r_cnt <= CW'(NK);
    end else if (r_state == KX_EXPAND) begin
      r_w[r_cnt] <= w_new;
      r_cnt      <= r_cnt + CW'(1);
    end
  end

  for (genvar r = 0; r <= ROUND_NUMBER; r++) begin : g_rk
    assign round_keys[r] = {r_w[NB*r], r_w[NB*r+1], r_w[NB*r+2], r_w[NB*r+3]};
  end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Bench for aes_key_expansion: FIPS-197 vectors, hold/reset/back-to-back
// scenarios and random keys against an independently derived key schedule.
module tb_aes_key_expansion;
  import aes_parameters::*;

  localparam int W = 128 * (ROUND_NUMBER + 1);
  localparam logic [255:0] KEY_A3 =
    256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
  localparam logic [255:0] KEY_C3 =
    256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [127:0] A3_RK2  = 128'h9ba35411_8e6925af_a51a8b5f_2067fcde;
  localparam logic [127:0] A3_RK14 = 128'hfe4890d1_e6188d0b_046df344_706c631e;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 reset;
  logic [KEY_WIDTH-1:0] key_in_tdata;
  logic                 key_in_tvalid;
  logic                 key_in_tready;
  logic                 keys_hold;
  round_keys_t          round_keys;
  logic                 round_keys_valid;
  logic                 busy;
  kx_state_e            dbg_state;

  always #5 clk = ~clk;

  aes_key_expansion dut (
    .clk              (clk),
    .reset            (reset),
    .key_in_tdata     (key_in_tdata),
    .key_in_tvalid    (key_in_tvalid),
    .key_in_tready    (key_in_tready),
    .keys_hold        (keys_hold),
    .round_keys       (round_keys),
    .round_keys_valid (round_keys_valid),
    .busy             (busy),
    .o_dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           n_checks  = 0;
  int           n_pass    = 0;
  int           ncyc      = 0;
  int           vcount    = 0;
  int           last_vlen = 0;
  logic         prev_valid = 1'b0;
  round_keys_t  mon_exp;
  logic [7:0]   sbox_ref [256];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from the GF(2^8) inverse and affine map, not from a table.
  function automatic void build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      if (a != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(a));
      end
      sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] sub_ref(input logic [31:0] t);
    return {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
  endfunction

  function automatic round_keys_t ref_expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    round_keys_t rk;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_ref({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end else if (i % 8 == 4) begin
        t = sub_ref(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  // ---------------- monitor: push on handshake, compare on valid rise ----------------
  always @(negedge clk) begin
    ncyc++;
    if (round_keys_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("valid_without_key", 128'(exp_q.size()), 128'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("latency", 128'(ncyc - acc_q.pop_front()), 128'd53);
        for (int r = 0; r <= ROUND_NUMBER; r++) begin
          check_eq($sformatf("rk%0d", r), round_keys[r], mon_exp[r]);
        end
      end
    end
    if (round_keys_valid) begin
      vcount++;
    end else if (prev_valid) begin
      last_vlen = vcount;
      vcount    = 0;
    end
    prev_valid = round_keys_valid;
    if (key_in_tvalid && key_in_tready) begin
      exp_q.push_back(ref_expand(key_in_tdata));
      acc_q.push_back(ncyc);
    end
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic send_key(input logic [255:0] key);
    bit hs;
    hs            = 1'b0;
    key_in_tdata  = key;
    key_in_tvalid = 1'b1;
    for (int i = 0; i < 300 && !hs; i++) begin
      @(negedge clk);
      hs = key_in_tready;
      @(posedge clk);
      #1;
    end
    key_in_tvalid = 1'b0;
    check_eq("send_handshake", 128'(hs), 128'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check_eq(tag, 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    logic [255:0] k1;
    logic [255:0] k2;
    build_sbox();
    reset         = 1'b1;
    key_in_tvalid = 1'b0;
    key_in_tdata  = '0;
    keys_hold     = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tready", 128'(key_in_tready), 128'd0);
    check_eq("rst_valid", 128'(round_keys_valid), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_rk0", round_keys[0], 128'd0);
    check_eq("rst_rk14", round_keys[14], 128'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("idle_tready", 128'(key_in_tready), 128'd1);
    check_eq("idle_busy", 128'(busy), 128'd0);
    @(posedge clk);
    #1;

    // FIPS-197 A.3
    send_key(KEY_A3);
    drain("a3_drain", 200);
    check_eq("a3_rk0", round_keys[0], KEY_A3[255:128]);
    check_eq("a3_w8_11", round_keys[2], A3_RK2);
    check_eq("a3_rk14", round_keys[14], A3_RK14);

    // Rekey blocked by keys_hold for 100 cycles, then C.3 key accepted
    keys_hold     = 1'b1;
    key_in_tdata  = KEY_C3;
    key_in_tvalid = 1'b1;
    bad           = 0;
    repeat (100) begin
      @(negedge clk);
      if (key_in_tready !== 1'b0 || round_keys_valid !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    check_eq("hold_blocked", 128'(bad), 128'd0);
    check_eq("hold_rk14", round_keys[14], A3_RK14);
    check_eq("hold_no_accept", 128'(exp_q.size()), 128'd0);
    keys_hold = 1'b0;
    @(negedge clk);
    check_eq("release_tready", 128'(key_in_tready), 128'd1);
    @(posedge clk);
    #1 key_in_tvalid = 1'b0;
    @(negedge clk);
    check_eq("rekey_valid_drop", 128'(round_keys_valid), 128'd0);
    check_eq("rekey_busy", 128'(busy), 128'd1);
    @(posedge clk);
    #1;
    drain("c3_drain", 200);
    check_eq("c3_rk0", round_keys[0], 128'h000102030405060708090a0b0c0d0e0f);
    check_eq("c3_rk1", round_keys[1], 128'h101112131415161718191a1b1c1d1e1f);

    // Reset in the middle of an expansion
    send_key(KEY_A3);
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_busy", 128'(busy), 128'd0);
    check_eq("midrst_valid", 128'(round_keys_valid), 128'd0);
    check_eq("midrst_tready", 128'(key_in_tready), 128'd0);
    check_eq("midrst_rk0", round_keys[0], 128'd0);
    check_eq("midrst_rk2", round_keys[2], 128'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("postrst_tready", 128'(key_in_tready), 128'd1);
    check_eq("postrst_busy", 128'(busy), 128'd0);
    check_eq("postrst_valid", 128'(round_keys_valid), 128'd0);
    @(posedge clk);
    #1;
    send_key(KEY_A3);
    drain("postrst_drain", 200);
    check_eq("postrst_rk14", round_keys[14], A3_RK14);

    // Back-to-back keys with tvalid held
    k1 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    k2 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    send_key(k1);
    send_key(k2);
    drain("b2b_drain", 200);
    check_eq("b2b_valid_width", 128'(last_vlen), 128'd1);

    // Random keys with occasional keys_hold pulses
    for (int n = 0; n < 200; n++) begin
      send_key({$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) begin
        keys_hold = 1'b1;
        repeat ($urandom_range(1, 70)) @(posedge clk);
        #1 keys_hold = 1'b0;
      end
    end
    drain("rand_drain", 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
